// File: rtl/aes_round_fsm_if.sv
// Stage bus between the AES round controller and its ARK/SBT/SHR/MXC submodules.
// The master side is the controller; the slave side is the submodule bank and result mux.
interface aes_round_fsm_if;
    logic         En_ARK, En_SBT, En_SHR, En_MXC;
    logic         Rst_ARK, Rst_SBT, Rst_SHR, Rst_MXC;
    logic         Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC;
    logic [127:0] Tx_out;
    logic [3:0]   KeySel;
    logic [3:0]   msg_sel;
    logic [127:0] msg_in;

    modport master (
        output En_ARK, En_SBT, En_SHR, En_MXC,
        output Rst_ARK, Rst_SBT, Rst_SHR, Rst_MXC,
        output Tx_out, KeySel, msg_sel,
        input  Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC,
        input  msg_in
    );

    modport slave (
        input  En_ARK, En_SBT, En_SHR, En_MXC,
        input  Rst_ARK, Rst_SBT, Rst_SHR, Rst_MXC,
        input  Tx_out, KeySel, msg_sel,
        output Ry_ARK, Ry_SBT, Ry_SHR, Ry_MXC,
        output msg_in
    );
endinterface

// File: rtl/aes_round_fsm.sv
// Control FSM of the iterative AES-128 encryptor: sequences ARK/SBT/SHR/MXC over the rounds.
// Optional stage-handshake watchdog with Err output is enabled by defining AES_FSM_TIMEOUT_EN.
module aes_round_fsm #(
    parameter int NUM_ROUNDS = 10
`ifdef AES_FSM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic [127:0]          PT,
    output logic [127:0]          CT,
    aes_round_fsm_if.master       bus,
    output logic                  Ry
`ifdef AES_FSM_TIMEOUT_EN
    , output logic                Err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARK,
        S_SBT,
        S_SHR,
        S_MXC,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t state;
    logic   ry_act;

`ifdef AES_FSM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
`endif

    // Bit order {MXC, SHR, SBT, ARK}; reused for both the enables and the Rst_* pulse.
    function automatic logic [3:0] en_of(input state_t s);
        case (s)
            S_ARK:   en_of = 4'b0001;
            S_SBT:   en_of = 4'b0010;
            S_SHR:   en_of = 4'b0100;
            S_MXC:   en_of = 4'b1000;
            default: en_of = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] sel_of(input state_t s);
        case (s)
            S_ARK:   sel_of = 4'd1;
            S_SBT:   sel_of = 4'd2;
            S_SHR:   sel_of = 4'd3;
            S_MXC:   sel_of = 4'd4;
            default: sel_of = 4'd0;
        endcase
    endfunction

    always_comb begin
        ry_act = 1'b0;
        case (state)
            S_ARK:   ry_act = bus.Ry_ARK;
            S_SBT:   ry_act = bus.Ry_SBT;
            S_SHR:   ry_act = bus.Ry_SHR;
            S_MXC:   ry_act = bus.Ry_MXC;
            default: ry_act = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state       <= S_IDLE;
            bus.Tx_out  <= '0;
            bus.KeySel  <= '0;
            bus.msg_sel <= '0;
            CT          <= '0;
            Ry          <= 1'b0;
            {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK}     <= '0;
            {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK} <= '1;
`ifdef AES_FSM_TIMEOUT_EN
            cnt <= '0;
            Err <= 1'b0;
`endif
        end else begin
            // Rst_* of a stage is a single-cycle pulse unless IDLE holds them high.
            {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK} <= '0;
`ifdef AES_FSM_TIMEOUT_EN
            cnt <= '0;
`endif
            case (state)
                S_IDLE: begin
                    {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK} <= '1;
                    if (En) begin
                        {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK} <= '0;
                        bus.Tx_out  <= PT;
                        bus.KeySel  <= '0;
                        state       <= S_ARK;
                        {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK} <= en_of(S_ARK);
                        bus.msg_sel <= sel_of(S_ARK);
`ifdef AES_FSM_TIMEOUT_EN
                        Err <= 1'b0;
`endif
                    end
                end

                S_DONE: begin
                    if (!En) begin
                        state <= S_IDLE;
                        Ry    <= 1'b0;
                        {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK} <= '1;
                    end
                end

                default: begin
                    if (ry_act) begin
                        bus.Tx_out <= bus.msg_in;
                        {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK} <= en_of(state);
                        case (state)
                            S_ARK: begin
                                if (bus.KeySel < LAST_ROUND) begin
                                    bus.KeySel  <= bus.KeySel + 4'd1;
                                    state       <= S_SBT;
                                    {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK} <= en_of(S_SBT);
                                    bus.msg_sel <= sel_of(S_SBT);
                                end else begin
                                    state       <= S_DONE;
                                    {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK} <= '0;
                                    bus.msg_sel <= '0;
                                    CT          <= bus.msg_in;
                                    Ry          <= 1'b1;
                                end
                            end
                            S_SBT: begin
                                state       <= S_SHR;
                                {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK} <= en_of(S_SHR);
                                bus.msg_sel <= sel_of(S_SHR);
                            end
                            S_SHR: begin
                                if (bus.KeySel < LAST_ROUND) begin
                                    state       <= S_MXC;
                                    {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK} <= en_of(S_MXC);
                                    bus.msg_sel <= sel_of(S_MXC);
                                end else begin
                                    state       <= S_ARK;
                                    {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK} <= en_of(S_ARK);
                                    bus.msg_sel <= sel_of(S_ARK);
                                end
                            end
                            S_MXC: begin
                                state       <= S_ARK;
                                {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK} <= en_of(S_ARK);
                                bus.msg_sel <= sel_of(S_ARK);
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end
`ifdef AES_FSM_TIMEOUT_EN
                    else if (cnt == TMO_LAST) begin
                        state       <= S_IDLE;
                        {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK}     <= '0;
                        {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK} <= '1;
                        bus.msg_sel <= '0;
                        Err         <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_fsm.sv
// Directed bench for aes_round_fsm: full 40-stage encryption, DONE/IDLE handoff,
// ignored foreign Ry_*, and synchronous reset abort in round 5 ShiftRows.
module tb_aes_round_fsm;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         En  = 1'b0;
    logic [127:0] PT  = '0;
    logic [127:0] CT;
    logic         Ry;
`ifdef AES_FSM_TIMEOUT_EN
    logic         Err;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] PT1 = 128'h328831e0435a3137f6309807a88da234;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

    aes_round_fsm_if bus ();

    aes_round_fsm #(.NUM_ROUNDS(10)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .En  (En),
        .PT  (PT),
        .CT  (CT),
        .bus (bus),
        .Ry  (Ry)
`ifdef AES_FSM_TIMEOUT_EN
        , .Err (Err)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] en_vec();
        return {bus.En_MXC, bus.En_SHR, bus.En_SBT, bus.En_ARK};
    endfunction

    function automatic logic [3:0] rst_vec();
        return {bus.Rst_MXC, bus.Rst_SHR, bus.Rst_SBT, bus.Rst_ARK};
    endfunction

    // Stage s (0..39): ARK, 9 x [SBT, SHR, MXC, ARK], SBT, SHR, ARK. Codes 1=ARK 2=SBT 3=SHR 4=MXC.
    function automatic int code_of(input int s);
        if (s == 0)  return 1;
        if (s == 37) return 2;
        if (s == 38) return 3;
        if (s == 39) return 1;
        case ((s - 1) % 4)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int round_of(input int s);
        if (s == 0)  return 0;
        if (s >= 37) return 10;
        return (s - 1) / 4 + 1;
    endfunction

    task automatic set_ry(input int c, input logic v);
        case (c)
            1:       bus.Ry_ARK = v;
            2:       bus.Ry_SBT = v;
            3:       bus.Ry_SHR = v;
            default: bus.Ry_MXC = v;
        endcase
    endtask

    // Called on the falling edge right after stage s became active; returns on the
    // falling edge after the FSM has consumed Ry for that stage.
    task automatic run_stage(input int s, input logic [127:0] tx_exp);
        int c;
        logic [3:0] onehot;
        logic [3:0] prev_rst;
        c = code_of(s);
        onehot = 4'b0001 << (c - 1);
        prev_rst = (s == 0) ? 4'b0000 : (4'b0001 << (code_of(s - 1) - 1));
        chk($sformatf("en_s%0d", s), en_vec(), onehot);
        chk($sformatf("keysel_s%0d", s), bus.KeySel, round_of(s));
        chk($sformatf("msgsel_s%0d", s), bus.msg_sel, c);
        chk($sformatf("tx_s%0d", s), bus.Tx_out, tx_exp);
        chk($sformatf("rstpulse_s%0d", s), rst_vec(), prev_rst);
        @(negedge Clk);
        chk($sformatf("rstclr_s%0d", s), rst_vec(), 4'b0000);
        if (s == 0) bus.Ry_SHR = 1'b1;
        @(negedge Clk);
        if (s == 0) begin
            chk("foreign_ry_en", en_vec(), 4'b0001);
            chk("foreign_ry_tx", bus.Tx_out, tx_exp);
            bus.Ry_SHR = 1'b0;
            bus.Ry_MXC = 1'b1;
        end
        set_ry(c, 1'b1);
        bus.msg_in = 128'(s + 1);
        @(negedge Clk);
        set_ry(c, 1'b0);
        bus.Ry_MXC = 1'b0;
    endtask

    initial begin
        bus.Ry_ARK = 1'b0;
        bus.Ry_SBT = 1'b0;
        bus.Ry_SHR = 1'b0;
        bus.Ry_MXC = 1'b0;
        bus.msg_in = '0;

        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk("rst_en", en_vec(), 4'b0000);
        chk("rst_rst", rst_vec(), 4'b1111);
        chk("rst_ry", Ry, 1'b0);
        chk("rst_keysel", bus.KeySel, 4'd0);
        chk("rst_tx", bus.Tx_out, 128'd0);
        chk("rst_ct", CT, 128'd0);
        chk("rst_msgsel", bus.msg_sel, 4'd0);

        PT = PT1;
        En = 1'b1;
        @(negedge Clk);
        for (int s = 0; s < 40; s++) begin
            run_stage(s, (s == 0) ? PT1 : 128'(s));
        end
        chk("done_en", en_vec(), 4'b0000);
        chk("done_ry", Ry, 1'b1);
        chk("done_ct", CT, 128'd40);
        chk("done_tx", bus.Tx_out, 128'd40);
        chk("done_keysel", bus.KeySel, 4'd10);
        chk("done_msgsel", bus.msg_sel, 4'd0);
        chk("done_rstark", rst_vec(), 4'b0001);
        @(negedge Clk);
        chk("done_hold_ry", Ry, 1'b1);
        chk("done_hold_rst", rst_vec(), 4'b0000);
        @(negedge Clk);
        chk("done_hold2_ry", Ry, 1'b1);
        chk("done_hold2_en", en_vec(), 4'b0000);
        En = 1'b0;
        @(negedge Clk);
        chk("idle_ry", Ry, 1'b0);
        chk("idle_ct_kept", CT, 128'd40);
        chk("idle_rst", rst_vec(), 4'b1111);
        chk("idle_en", en_vec(), 4'b0000);

        // Second run: En dropped after start, then reset while in round 5 ShiftRows.
        PT = PT2;
        En = 1'b1;
        @(negedge Clk);
        En = 1'b0;
        for (int s = 0; s < 18; s++) begin
            run_stage(s, (s == 0) ? PT2 : 128'(s));
        end
        chk("r5shr_en", en_vec(), 4'b0100);
        chk("r5shr_keysel", bus.KeySel, 4'd5);
        chk("r5shr_tx", bus.Tx_out, 128'd18);
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort_en", en_vec(), 4'b0000);
        chk("abort_keysel", bus.KeySel, 4'd0);
        chk("abort_tx", bus.Tx_out, 128'd0);
        chk("abort_rst", rst_vec(), 4'b1111);
        chk("abort_msgsel", bus.msg_sel, 4'd0);
        chk("abort_ry", Ry, 1'b0);
        Rst = 1'b1;
        En  = 1'b1;
        @(negedge Clk);
        chk("restart_en", en_vec(), 4'b0001);
        chk("restart_keysel", bus.KeySel, 4'd0);
        chk("restart_tx", bus.Tx_out, PT2);
        chk("restart_msgsel", bus.msg_sel, 4'd1);
        chk("restart_rst", rst_vec(), 4'b0000);
        En = 1'b0;
        @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
